// File: rtl/progmem_pkg.sv
// Shared types for the program-memory arbiter: widths, read-owner tag, two-way round-robin pick.
package progmem_pkg;

  localparam int PM_ADDR_W = 7;
  localparam int PM_DATA_W = 32;

  typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B} sel_t;

  // Picks the read owner; on contention the port that did not win last time gets it.
  function automatic sel_t rr_pick(input logic a_want, input logic b_want, input sel_t last);
    if (a_want && b_want) return (last == SEL_A) ? SEL_B : SEL_A;
    if (a_want)           return SEL_A;
    if (b_want)           return SEL_B;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/progmem_arbiter_if.sv
// Requester and memory-side signals of the program-memory arbiter.
interface progmem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              pm_rden;
  logic [ADDR_W-1:0] pm_rdaddress;
  logic              pm_wren;
  logic [ADDR_W-1:0] pm_wraddress;
  logic [DATA_W-1:0] pm_data;
  logic [DATA_W-1:0] pm_q;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, pm_q,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           pm_rden, pm_rdaddress, pm_wren, pm_wraddress, pm_data
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, pm_q,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           pm_rden, pm_rdaddress, pm_wren, pm_wraddress, pm_data
  );
endinterface

// File: rtl/progmem_arbiter.sv
// Arbitrates one read and one write per cycle into the program memory for fetch (A) and loader (B);
// read data returns with rvalid one cycle after grant; requesters hold until gnt.
module progmem_arbiter
  import progmem_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int DATA_W = PM_DATA_W
) (
  input logic               clock,
  input logic               reset,
  progmem_arbiter_if.slave  bus
);

  sel_t sel_q, sel_d;
  sel_t rr_last, rr_d;
  sel_t pick;

  logic              b_rd, b_wr, raw_hit, contended;
  logic              a_gnt_c, b_rd_gnt, b_wr_gnt;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data, a_rdata_c, b_rdata_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q   <= SEL_NONE;
      rr_last <= SEL_B;
    end else begin
      sel_q   <= sel_d;
      rr_last <= rr_d;
    end
  end

  always_comb begin
    b_rd      = bus.b_req & ~bus.b_we;
    b_wr      = bus.b_req & bus.b_we;
    // A same-address write wins so the held fetch reads the new word next cycle.
    raw_hit   = b_wr & bus.a_req & (bus.a_addr == bus.b_addr);
    pick      = rr_pick(bus.a_req & ~raw_hit, b_rd, rr_last);
    contended = bus.a_req & b_rd;

    a_gnt_c  = 1'b0;
    b_rd_gnt = 1'b0;
    b_wr_gnt = 1'b0;
    sel_d    = SEL_NONE;
    rr_d     = rr_last;
    if (!reset) begin
      a_gnt_c  = (pick == SEL_A);
      b_rd_gnt = (pick == SEL_B);
      b_wr_gnt = b_wr;
      sel_d    = pick;
      if (contended) rr_d = pick;
    end

    rd_addr = '0;
    if (a_gnt_c)       rd_addr = bus.a_addr;
    else if (b_rd_gnt) rd_addr = bus.b_addr;

    wr_addr = b_wr_gnt ? bus.b_addr  : '0;
    wr_data = b_wr_gnt ? bus.b_wdata : '0;

    a_rdata_c = (sel_q == SEL_A) ? bus.pm_q : '0;
    b_rdata_c = (sel_q == SEL_B) ? bus.pm_q : '0;
  end

  assign bus.a_gnt        = a_gnt_c;
  assign bus.b_gnt        = b_rd_gnt | b_wr_gnt;
  assign bus.pm_rden      = a_gnt_c | b_rd_gnt;
  assign bus.pm_rdaddress = rd_addr;
  assign bus.pm_wren      = b_wr_gnt;
  assign bus.pm_wraddress = wr_addr;
  assign bus.pm_data      = wr_data;
  assign bus.a_rvalid     = (sel_q == SEL_A);
  assign bus.b_rvalid     = (sel_q == SEL_B);
  assign bus.a_rdata      = a_rdata_c;
  assign bus.b_rdata      = b_rdata_c;

endmodule

// File: tb/tb_progmem_arbiter.sv
// Bench for progmem_arbiter: memory model, reference model checked every cycle, directed and random stimulus.
module tb_progmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  progmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  progmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Physical memory the DUT drives: registered read address, read returns old data.
  logic [DW-1:0] mem [128];
  logic [DW-1:0] q;
  always @(posedge clock) begin
    if (bus.pm_wren) mem[bus.pm_wraddress] <= bus.pm_data;
    if (bus.pm_rden) q <= mem[bus.pm_rdaddress];
  end
  assign bus.pm_q = q;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'h1234_5678;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, who read last cycle, who won the last contention.
  logic [31:0] shadow [128];
  int          exp_sel = 0;     // 0 none, 1 A, 2 B
  logic [31:0] exp_dat = '0;
  bit          last_b = 1'b1;

  logic        e_ag, e_bg, e_brd, e_bwr;
  logic [6:0]  e_rda;

  always @(negedge clock) begin
    e_ag = 1'b0; e_bg = 1'b0; e_brd = 1'b0; e_bwr = 1'b0; e_rda = '0;
    if (!reset) begin
      if (bus.b_req && bus.b_we) begin
        e_bg  = 1'b1;
        e_bwr = 1'b1;
        e_ag  = bus.a_req && (bus.a_addr != bus.b_addr);
      end else if (bus.a_req && bus.b_req) begin
        e_ag  = last_b;
        e_bg  = !last_b;
        e_brd = !last_b;
      end else begin
        e_ag  = bus.a_req;
        e_bg  = bus.b_req;
        e_brd = bus.b_req;
      end
      if (e_ag) e_rda = bus.a_addr;
      else if (e_brd) e_rda = bus.b_addr;
    end

    chk("a_gnt",        32'(bus.a_gnt),        32'(e_ag));
    chk("b_gnt",        32'(bus.b_gnt),        32'(e_bg));
    chk("pm_rden",      32'(bus.pm_rden),      32'(e_ag | e_brd));
    chk("pm_rdaddress", 32'(bus.pm_rdaddress), 32'(e_rda));
    chk("pm_wren",      32'(bus.pm_wren),      32'(e_bwr));
    chk("pm_wraddress", 32'(bus.pm_wraddress), e_bwr ? 32'(bus.b_addr) : 32'd0);
    chk("pm_data",      bus.pm_data,           e_bwr ? bus.b_wdata : 32'd0);
    chk("a_rvalid",     32'(bus.a_rvalid),     32'(!reset && exp_sel == 1));
    chk("b_rvalid",     32'(bus.b_rvalid),     32'(!reset && exp_sel == 2));
    chk("a_rdata",      bus.a_rdata,           (!reset && exp_sel == 1) ? exp_dat : 32'd0);
    chk("b_rdata",      bus.b_rdata,           (!reset && exp_sel == 2) ? exp_dat : 32'd0);

    if (reset) begin
      exp_sel = 0;
      last_b  = 1'b1;
    end else begin
      exp_sel = e_ag ? 1 : (e_brd ? 2 : 0);
      if (e_ag)  exp_dat = shadow[bus.a_addr];
      if (e_brd) exp_dat = shadow[bus.b_addr];
      if (bus.a_req && bus.b_req && !bus.b_we) last_b = e_brd;
      if (e_bwr) shadow[bus.b_addr] = bus.b_wdata;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [6:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 7'($urandom_range(0, 3));
    return 7'($urandom_range(0, 127));
  endfunction

  logic ag, bg;
  int   rv_count;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    at_neg();
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("rst_b_rdata",  bus.b_rdata,       32'd0);
    step(); step();
    reset = 1'b0;

    // 1: single fetch of word 5
    bus.a_req = 1'b1; bus.a_addr = 7'd5;
    at_neg(); chk("t1_a_gnt", 32'(bus.a_gnt), 32'd1);
    step(); bus.a_req = 1'b0;
    at_neg();
    chk("t1_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t1_a_rdata",  bus.a_rdata,       32'h1234_5678);
    chk("t1_b_rvalid", 32'(bus.b_rvalid), 32'd0);

    // 2: contended reads alternate A,B,A,B
    step();
    bus.a_req = 1'b1; bus.a_addr = 7'd3;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd9;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("t2_a_gnt", 32'(bus.a_gnt), 32'(i % 2 == 0));
      chk("t2_b_gnt", 32'(bus.b_gnt), 32'(i % 2 == 1));
      if (i > 0) chk("t2_rdata", bus.a_rdata | bus.b_rdata, (i % 2 == 1) ? init_word(3) : init_word(9));
      step();
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    at_neg(); chk("t2_last_b_rdata", bus.b_rdata, init_word(9));

    // 3: write 10 alongside read 20, both go
    step();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 7'd10; bus.b_wdata = 32'hDEAD_BEEF;
    bus.a_req = 1'b1; bus.a_addr = 7'd20;
    at_neg();
    chk("t3_gnts", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd3);
    chk("t3_pm_en", {30'd0, bus.pm_rden, bus.pm_wren}, 32'd3);
    step(); bus.a_req = 1'b0; bus.b_req = 1'b0;
    at_neg(); chk("t3_a_rdata", bus.a_rdata, init_word(20));

    // 4: same-address write then read sees new data
    step();
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 7'd10; bus.b_wdata = 32'hCAFE_0001;
    bus.a_req = 1'b1; bus.a_addr = 7'd10;
    at_neg();
    chk("t4_b_gnt", 32'(bus.b_gnt), 32'd1);
    chk("t4_a_gnt_blocked", 32'(bus.a_gnt), 32'd0);
    step(); bus.b_req = 1'b0;
    at_neg(); chk("t4_a_gnt_next", 32'(bus.a_gnt), 32'd1);
    step(); bus.a_req = 1'b0;
    at_neg();
    chk("t4_a_rvalid", 32'(bus.a_rvalid), 32'd1);
    chk("t4_a_rdata",  bus.a_rdata,       32'hCAFE_0001);

    // 5: reset drops an outstanding read and restores A priority
    step();
    bus.a_req = 1'b1; bus.a_addr = 7'd7;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 7'd8;
    at_neg(); chk("t5_a_wins", 32'(bus.a_gnt), 32'd1);
    step(); bus.a_req = 1'b0; bus.b_req = 1'b0; reset = 1'b1;
    at_neg(); chk("t5_rvalid_in_rst", 32'(bus.a_rvalid), 32'd0);
    step(); reset = 1'b0;
    at_neg(); chk("t5_rvalid_after", 32'(bus.a_rvalid), 32'd0);
    step();
    bus.a_req = 1'b1; bus.a_addr = 7'd1;
    bus.b_req = 1'b1; bus.b_addr = 7'd2;
    at_neg(); chk("t5_first_contention", 32'(bus.a_gnt), 32'd1);
    step(); bus.a_req = 1'b0; bus.b_req = 1'b0;
    step();

    // 6: sweep all addresses and wrap to 0
    rv_count = 0;
    bus.a_req = 1'b1;
    for (int i = 0; i <= 128; i++) begin
      bus.a_addr = 7'(i % 128);
      at_neg();
      chk("t6_a_gnt", 32'(bus.a_gnt), 32'd1);
      if (bus.a_rvalid) rv_count++;
      step();
    end
    bus.a_req = 1'b0;
    at_neg();
    if (bus.a_rvalid) rv_count++;
    chk("t6_wrap_rdata", bus.a_rdata, init_word(0));
    chk("t6_rvalid_count", 32'(rv_count), 32'd129);

    // Random traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      ag = bus.a_gnt;
      bg = bus.b_gnt;
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (!bus.a_req || ag) begin
        bus.a_req  = ($urandom_range(0, 9) < 6);
        bus.a_addr = rnd_addr();
      end
      if (!bus.b_req || bg) begin
        bus.b_req   = ($urandom_range(0, 9) < 5);
        bus.b_we    = 1'($urandom_range(0, 1));
        bus.b_addr  = rnd_addr();
        bus.b_wdata = $urandom;
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0; reset = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
